// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALU sequencer (alu_seq_ctrl and alu_seq_unpack).
package alu_seq_pkg;

  localparam int WORD_W_DEF = 16;

  localparam logic [2:0] MC_64 = 3'b111;
  localparam logic [2:0] MC_32 = 3'b110;
  localparam logic [2:0] MC_16 = 3'b100;

  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2,
    SEND  = 2'd3
  } state_e;

  function automatic logic mc_legal(input logic [2:0] mc);
    return (mc == MC_64) || (mc == MC_32) || (mc == MC_16);
  endfunction

endpackage

// File: rtl/alu_seq_unpack.sv
// Selects result word k (0..3) from the captured ALU result ports according to the lane mode.
module alu_seq_unpack
  import alu_seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic [2:0]          mc_i,
  input  logic [1:0]          idx_i,
  input  logic [4*WORD_W-1:0] res1_i,
  input  logic [2*WORD_W-1:0] res2_i,
  input  logic [WORD_W-1:0]   res3_i,
  input  logic [WORD_W-1:0]   res4_i,
  output logic [WORD_W-1:0]   word_o
);

  always_comb begin
    word_o = res1_i[idx_i*WORD_W +: WORD_W];
    case (mc_i)
      MC_32: begin
        case (idx_i)
          2'd0:    word_o = res1_i[0      +: WORD_W];
          2'd1:    word_o = res1_i[WORD_W +: WORD_W];
          2'd2:    word_o = res2_i[0      +: WORD_W];
          default: word_o = res2_i[WORD_W +: WORD_W];
        endcase
      end
      MC_16: begin
        case (idx_i)
          2'd0:    word_o = res1_i[0 +: WORD_W];
          2'd1:    word_o = res2_i[0 +: WORD_W];
          2'd2:    word_o = res3_i;
          default: word_o = res4_i;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Stream front/back end for the lane-partitioned ALU: load 8 operand words, wait ALU_LAT, stream 4 result words.
// Optional macro ALU_SEQ_OPCNT_EN adds op_count, a wrapping count of completed transactions.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_mc,
  input  logic [1:0]          cmd_op,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  output logic [2:0]          alu_mc,
  output logic [1:0]          alu_op,
  output logic [WORD_W-1:0]   alu_a0,
  output logic [WORD_W-1:0]   alu_a1,
  output logic [WORD_W-1:0]   alu_a2,
  output logic [WORD_W-1:0]   alu_a3,
  output logic [WORD_W-1:0]   alu_b0,
  output logic [WORD_W-1:0]   alu_b1,
  output logic [WORD_W-1:0]   alu_b2,
  output logic [WORD_W-1:0]   alu_b3,
  input  logic [4*WORD_W-1:0] alu_res1,
  input  logic [2*WORD_W-1:0] alu_res2,
  input  logic [WORD_W-1:0]   alu_res3,
  input  logic [WORD_W-1:0]   alu_res4,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                err
`ifdef ALU_SEQ_OPCNT_EN
  , output logic [15:0]       op_count
`endif
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [3:0]          wait_q, wait_d;
  logic [2:0]          mc_q, mc_d;
  logic [1:0]          op_q, op_d;
  logic                err_q, err_d;
  logic                load_en, cap_en, done;
  logic [WORD_W-1:0]   opnd_q [8];
  logic [4*WORD_W-1:0] res1_q;
  logic [2*WORD_W-1:0] res2_q;
  logic [WORD_W-1:0]   res3_q, res4_q;
  logic [WORD_W-1:0]   word;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    mc_d    = mc_q;
    op_d    = op_q;
    err_d   = 1'b0;
    load_en = 1'b0;
    cap_en  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (mc_legal(cmd_mc)) begin
            mc_d    = cmd_mc;
            op_d    = cmd_op;
            idx_d   = 3'd0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          load_en = 1'b1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            wait_d  = 4'd0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Capture lands exactly ALU_LAT edges after entering ISSUE.
        if (wait_q == LAT_LAST) begin
          cap_en  = 1'b1;
          idx_d   = 3'd0;
          state_d = SEND;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      SEND: begin
        if (out_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd3) begin
            idx_d   = 3'd0;
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      mc_q    <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      res1_q  <= '0;
      res2_q  <= '0;
      res3_q  <= '0;
      res4_q  <= '0;
      for (int i = 0; i < 8; i++) opnd_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      mc_q    <= mc_d;
      op_q    <= op_d;
      err_q   <= err_d;
      if (load_en) opnd_q[idx_q] <= in_data;
      if (cap_en) begin
        res1_q <= alu_res1;
        res2_q <= alu_res2;
        res3_q <= alu_res3;
        res4_q <= alu_res4;
      end
    end
  end

`ifdef ALU_SEQ_OPCNT_EN
  logic [15:0] opcnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)    opcnt_q <= '0;
    else if (done) opcnt_q <= opcnt_q + 16'd1;
  end
  assign op_count = opcnt_q;
`else
  logic unused_done;
  assign unused_done = done;
`endif

  alu_seq_unpack #(.WORD_W(WORD_W)) u_unpack (
    .mc_i   (mc_q),
    .idx_i  (idx_q[1:0]),
    .res1_i (res1_q),
    .res2_i (res2_q),
    .res3_i (res3_q),
    .res4_i (res4_q),
    .word_o (word)
  );

  assign cmd_ready = (state_q == IDLE);
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (idx_q == 3'd3);
  assign out_data  = out_valid ? word : '0;
  assign err       = err_q;
  assign alu_mc    = mc_q;
  assign alu_op    = op_q;
  assign alu_a0    = opnd_q[0];
  assign alu_a1    = opnd_q[1];
  assign alu_a2    = opnd_q[2];
  assign alu_a3    = opnd_q[3];
  assign alu_b0    = opnd_q[4];
  assign alu_b1    = opnd_q[5];
  assign alu_b2    = opnd_q[6];
  assign alu_b3    = opnd_q[7];

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequential front/back end for the lane-partitioned 16/32/64-bit ALU.
- Accepts a command (mode + op) and eight 16-bit operand words over a valid/ready stream.
- Presents the assembled operands to the ALU, waits a fixed latency, then captures the result ports.
- Unpacks the result by mode and streams it out as four 16-bit words over a second valid/ready stream.
- Sits between the bus-side word streams and the combinational ALU.

Parameters:
WORD_W, 16, width of every operand and result word
ALU_LAT, 1, cycles between the first ISSUE cycle and the capture cycle (1..15)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_mc  in  3  mode: 111 = 64-bit, 110 = 2x32-bit, 100 = 4x16-bit
cmd_op  in  2  op: 10 = add, 00 = sub, 11 = xor
in_valid  in  1  operand word present
in_ready  out  1  high only in LOAD
in_data  in  16  operand word; order A0,A1,A2,A3,B0,B1,B2,B3 (lane 0 = least significant)
alu_mc  out  3  registered mode to ALU
alu_op  out  2  registered op to ALU
alu_a0..alu_a3  out  16 each  A lanes to ALU word1..word4
alu_b0..alu_b3  out  16 each  B lanes to ALU word31..word34
alu_res1  in  64  ALU result 1
alu_res2  in  32  ALU result 2
alu_res3  in  16  ALU result 3
alu_res4  in  16  ALU result 4
out_valid  out  1  result word present
out_ready  in  1  sink accepts word
out_data  out  16  result word
out_last  out  1  high with 4th result word
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle pulse on illegal cmd_mc

Behaviour:
Reset (rst_n low at clock edge):
- State goes to IDLE.
- All outputs, registers and counters go to 0, including out_valid and err.
- Reset has priority over everything, including mid-LOAD or mid-SEND; partial transfers are discarded.

States:
- IDLE: cmd_ready=1. On cmd_valid with legal mc (111/110/100): latch mc and op, clear word index, go to LOAD.
  - On illegal mc: err=1 for the next cycle, stay in IDLE, nothing latched.
  - op is passed through unchecked.
- LOAD: in_ready=1. Each in_valid&in_ready stores in_data at index idx (0..7) and increments idx.
  - Transfer at idx=7 goes to ISSUE.
  - Stalls indefinitely while in_valid=0.
- ISSUE: alu_* outputs are stable from entry until leaving SEND.
  - Wait counter counts ALU_LAT cycles; on the last one, capture alu_res1..4 into the result register and go to SEND.
  - Result is therefore captured exactly ALU_LAT cycles after the LOAD->ISSUE edge.
- SEND: out_valid=1, out_data=unpack(idx).
  - idx advances on out_valid&out_ready; out_last=1 at idx=3.
  - Transfer at idx=3 returns to IDLE; out_valid drops the next cycle.
  - out_data and out_valid must hold stable while out_ready=0.

Unpack by latched mc, word k=0..3:
- 111: res1[16k+15:16k].
- 110: k0=res1[15:0], k1=res1[31:16], k2=res2[15:0], k3=res2[31:16].
- 100: k0=res1[15:0], k1=res2[15:0], k2=res3, k3=res4.

Other rules:
- cmd_valid during LOAD/ISSUE/SEND is ignored (cmd_ready=0).
- No back-to-back overlap: a new command is accepted only in IDLE.
- Minimum transaction: 1 (cmd) + 8 (load) + ALU_LAT + 4 (send) cycles.

Optional Feature:
ALU_SEQ_OPCNT_EN:
- Defined: adds output op_count[15:0], incremented on each completed SEND (last word accepted).
  - Wraps 0xFFFF->0x0000.
  - Cleared by reset; not incremented by illegal-mc commands.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
Package alu_seq_pkg holds:
- state enum {IDLE, LOAD, ISSUE, SEND}
- MC_64=3'b111, MC_32=3'b110, MC_16=3'b100
- OP_ADD=2'b10, OP_SUB=2'b00, OP_XOR=2'b11
- WORD_W default

One sub-module, alu_seq_unpack: combinational (mc, idx, captured res1..4) -> 16-bit word.

Test Plan:
- 64-bit result order: mc=111, op=10, res1 model=0x0004_0003_0002_0001 -> out_data 0x0001,0x0002,0x0003,0x0004; out_last on 4th; capture exactly ALU_LAT cycles after ISSUE.
- 16-bit lanes: mc=100, res1[15:0]=0xAAAA, res2[15:0]=0xBBBB, res3=0xCCCC, res4=0xDDDD -> 0xAAAA,0xBBBB,0xCCCC,0xDDDD.
- Operand mapping: load 0x0001,0x0001,0x0000,0x0001,0x0000,0x0000,0x0000,0x0001 -> alu_a0..a3 = 1,1,0,1 and alu_b3=1, others 0; alu_op=11 held through SEND.
- Backpressure: out_ready toggled 0/1 every cycle, and in_valid gaps of 3 cycles during LOAD -> no lost or duplicated words; out_data stable while stalled.
- Illegal mc=3'b010 -> err pulse of exactly 1 cycle, busy stays 0, in_ready stays 0.
- Reset mid-SEND after word 1 -> next cycle all outputs 0, state IDLE; a fresh mc=110 transaction completes correctly; op_count (if ALU_SEQ_OPCNT_EN) reads 1.
